// File: rtl/alu_lanes.sv
// ============================================================================
// Module   : alu_lanes
// Brief    : Six-lane SIMD integer ALU; per-lane results and Z/C flags are
//            registered (1-cycle latency). Optional build macro ALU_SAT_EN
//            enables unsigned saturation for ADD/SUB/MUL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_lanes #(
  parameter int N     = 8,
  parameter int LANES = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0][N-1:0]    SrcAE,
  input  logic [LANES-1:0][N-1:0]    SrcBE,
  input  logic [2:0]                 ALUControl,
  output logic [1:0][LANES-1:0]      ALUFlags,
  output logic [LANES-1:0][N-1:0]    vector
);

  localparam logic [2:0] C_OP_ADD = 3'b000;
  localparam logic [2:0] C_OP_SUB = 3'b001;
  localparam logic [2:0] C_OP_MOV = 3'b010;
  localparam logic [2:0] C_OP_MUL = 3'b011;
  localparam logic [2:0] C_OP_AND = 3'b100;
  localparam logic [2:0] C_OP_OR  = 3'b101;
  localparam logic [2:0] C_OP_XOR = 3'b110;

  logic [LANES-1:0][N-1:0] vector_d;
  logic [LANES-1:0]        zero_d;
  logic [LANES-1:0]        carry_d;

  logic [LANES-1:0][N-1:0] vector_q;
  logic [1:0][LANES-1:0]   flags_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [N:0]     w_sum;
    logic [N:0]     w_diff;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_res;
    logic           w_carry;

    assign w_sum  = {1'b0, SrcAE[i]} + {1'b0, SrcBE[i]};
    // Subtract as A + ~B + 1 so the carry out directly means "no borrow".
    assign w_diff = {1'b0, SrcAE[i]} + {1'b0, ~SrcBE[i]} + {{N{1'b0}}, 1'b1};
    assign w_prod = {{N{1'b0}}, SrcAE[i]} * {{N{1'b0}}, SrcBE[i]};

    always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      case (ALUControl)
        C_OP_ADD: begin
          w_res   = w_sum[N-1:0];
          w_carry = w_sum[N];
`ifdef ALU_SAT_EN
          if (w_sum[N]) w_res = '1;
`endif
        end
        C_OP_SUB: begin
          w_res   = w_diff[N-1:0];
          w_carry = w_diff[N];
`ifdef ALU_SAT_EN
          if (!w_diff[N]) w_res = '0;
`endif
        end
        C_OP_MOV: w_res = SrcBE[i];
        C_OP_MUL: begin
          w_res   = w_prod[N-1:0];
          w_carry = |w_prod[2*N-1:N];
`ifdef ALU_SAT_EN
          if (|w_prod[2*N-1:N]) w_res = '1;
`endif
        end
        C_OP_AND: w_res = SrcAE[i] & SrcBE[i];
        C_OP_OR:  w_res = SrcAE[i] | SrcBE[i];
        C_OP_XOR: w_res = SrcAE[i] ^ SrcBE[i];
        default: begin
          w_res   = '0;
          w_carry = 1'b0;
        end
      endcase
    end

    // Z is taken from the final (possibly saturated) result.
    assign vector_d[i] = w_res;
    assign zero_d[i]   = (w_res == '0);
    assign carry_d[i]  = w_carry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vector_q <= '0;
      flags_q  <= '0;
    end else begin
      vector_q   <= vector_d;
      flags_q[0] <= zero_d;
      flags_q[1] <= carry_d;
    end
  end

  assign vector   = vector_q;
  assign ALUFlags = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_lanes.sv
// ============================================================================
// Module   : tb_alu_lanes
// Brief    : Scoreboard bench for alu_lanes (honours ALU_SAT_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_lanes;

  localparam int N     = 8;
  localparam int LANES = 6;
`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic [LANES-1:0][N-1:0] vec_t;
  typedef logic [1:0][LANES-1:0]   flg_t;
  typedef struct packed {
    vec_t v;
    flg_t f;
  } exp_t;

  logic       clk;
  logic       rst;
  vec_t       SrcAE;
  vec_t       SrcBE;
  logic [2:0] ALUControl;
  flg_t       ALUFlags;
  vec_t       vector;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];

  alu_lanes #(.N(N), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .ALUControl (ALUControl),
    .ALUFlags   (ALUFlags),
    .vector     (vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic, no bit tricks.
  function automatic exp_t model(input vec_t a, input vec_t b, input logic [2:0] op);
    exp_t e;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      int unsigned x, y, r;
      bit c;
      x = a[i];
      y = b[i];
      r = 0;
      c = 1'b0;
      case (op)
        3'd0: begin
          r = x + y;
          c = (r > 255);
          if (c) r = SAT ? 255 : r - 256;
        end
        3'd1: begin
          c = (x >= y);
          r = c ? x - y : (SAT ? 0 : x + 256 - y);
        end
        3'd2: r = y;
        3'd3: begin
          r = x * y;
          c = (r > 255);
          if (c) r = SAT ? 255 : r % 256;
        end
        3'd4: r = x & y;
        3'd5: r = x | y;
        3'd6: r = x ^ y;
        default: r = 0;
      endcase
      e.v[i]    = r[7:0];
      e.f[0][i] = (r == 0);
      e.f[1][i] = c;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b1) exp_q.push_back(model(SrcAE, SrcBE, ALUControl));
  end

  always @(negedge rst) exp_q.delete();

  always @(negedge clk) begin
    if (rst === 1'b1 && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sb_vector", vector, e.v);
      check("sb_flags", {36'd0, ALUFlags}, {36'd0, e.f});
    end else if (rst === 1'b0) begin
      check("rst_hold_vector", vector, 48'd0);
      check("rst_hold_flags", {36'd0, ALUFlags}, 48'd0);
    end
  end

  task automatic drive(input vec_t a, input vec_t b, input logic [2:0] op);
    SrcAE      = a;
    SrcBE      = b;
    ALUControl = op;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t splat(input logic [7:0] x);
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = x;
    return v;
  endfunction

  initial begin
    vec_t a, b, ev;
    rst        = 1'b0;
    SrcAE      = splat(8'hA5);
    SrcBE      = splat(8'h3C);
    ALUControl = 3'd3;
    #2;
    check("reset_vector", vector, 48'd0);
    check("reset_flags", {36'd0, ALUFlags}, 48'd0);
    @(posedge clk);
    #1;

    // Release and first ADD 1+10 in lane 0.
    rst = 1'b1;
    a = '0; b = '0; a[0] = 8'd1; b[0] = 8'd10;
    drive(a, b, 3'd0);
    ev = '0; ev[0] = 8'd11;
    check("first_add_vec", vector, ev);
    check("first_add_z", {42'd0, ALUFlags[0]}, 48'h3E);
    check("first_add_c", {42'd0, ALUFlags[1]}, 48'h00);

    // SUB 10-5 (lane 0), 0-0 elsewhere.
    a = '0; b = '0; a[0] = 8'd10; b[0] = 8'd5;
    drive(a, b, 3'd1);
    ev = '0; ev[0] = 8'd5;
    check("sub_vec", vector, ev);
    check("sub_c", {42'd0, ALUFlags[1]}, 48'h3F);

    a = '0; b = '0; a[0] = 8'd11; b[0] = 8'd11;
    drive(a, b, 3'd2);
    ev = '0; ev[0] = 8'd11;
    check("mov_vec", vector, ev);
    check("mov_c", {42'd0, ALUFlags[1]}, 48'h00);

    // MUL 5*5, then 16*16 in lane 2.
    a = '0; b = '0; a[0] = 8'd5; b[0] = 8'd5;
    drive(a, b, 3'd3);
    check("mul_lane0", {40'd0, vector[0]}, 48'd25);
    a = '0; b = '0; a[2] = 8'd16; b[2] = 8'd16;
    drive(a, b, 3'd3);
    check("mul_ovf_lane2", {40'd0, vector[2]}, SAT ? 48'd255 : 48'd0);
    check("mul_ovf_c", {42'd0, ALUFlags[1]}, 48'h04);

    // Per-lane wrap, no inter-lane carry.
    drive(splat(8'hFF), splat(8'h01), 3'd0);
    check("add_wrap_vec", vector, SAT ? {LANES{8'hFF}} : 48'd0);
    check("add_wrap_z", {42'd0, ALUFlags[0]}, SAT ? 48'h00 : 48'h3F);
    check("add_wrap_c", {42'd0, ALUFlags[1]}, 48'h3F);

    // SUB 0-1 borrow.
    drive(splat(8'h00), splat(8'h01), 3'd1);
    check("sub_borrow_vec", vector, SAT ? 48'd0 : {LANES{8'hFF}});
    check("sub_borrow_c", {42'd0, ALUFlags[1]}, 48'h00);

    // Back-to-back op sweep; scoreboard checks each cycle.
    for (int op = 0; op < 8; op++) drive(splat(8'hC3), splat(8'h5A), op[2:0]);
    check("reserved_vec", vector, 48'd0);
    check("reserved_z", {42'd0, ALUFlags[0]}, 48'h3F);

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < LANES; i++) begin
        a[i] = 8'($urandom_range(0, 255));
        b[i] = (k % 5 == 0) ? a[i] : 8'($urandom_range(0, 255));
      end
      drive(a, b, 3'($urandom_range(0, 7)));
    end

    // Async reset between edges.
    drive(splat(8'h77), splat(8'h11), 3'd0);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_vec", vector, 48'd0);
    check("async_rst_flags", {36'd0, ALUFlags}, 48'd0);
    @(posedge clk);
    #1;
    check("async_hold_vec", vector, 48'd0);
    rst = 1'b1;
    drive(splat(8'h20), splat(8'h03), 3'd6);
    check("post_rst_xor", vector, {LANES{8'h23}});

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
